// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit -- RV32I instruction fetch stage.
//
// Holds the PC, issues word fetches to instruction memory and buffers the
// returned words in an in-order prefetch FIFO. Decode reads {inst, pc} from
// the head of that FIFO. Redirects flush the FIFO. Responses to requests that
// were already in flight at a redirect are counted and thrown away.
//
// Optional feature (compile-time macro FETCH_MISALIGN_CHK_EN):
//   When the macro is defined, a redirect whose target has a non-zero low
//   2-bit field sets the sticky fetch_misaligned flag. Fetch then halts until
//   reset. When the macro is undefined, the low target bits are masked off
//   and fetch continues.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_rsp_*        in-order response channel (never back-pressured)
//   redirect_*        single-cycle control-flow redirect
//   if_*              {inst, pc} to decode with a valid/ready handshake
//   fetch_misaligned  sticky misaligned-redirect flag (optional feature only)

module rv_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic [ADDR_WIDTH-1:0] if_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                  fetch_misaligned
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]        out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0]        drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]        occ_reg, occ_next;
    logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]        trk_wr_ptr_reg, trk_rd_ptr_reg;

    // Prefetch FIFO storage and the tracker that remembers request addresses
    // in issue order, so each response can be tagged with its PC.
    logic [DATA_WIDTH-1:0]   fifo_inst_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc_mem   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   trk_mem       [FIFO_DEPTH];

    logic                    run;
    logic                    req_fire;
    logic                    redirect_take;
    logic                    flush;
    logic                    fifo_wr;
    logic                    fifo_rd;
    logic                    rsp_drop;
    logic [ADDR_WIDTH-1:0]   redirect_pc_aligned;
    logic                    misalign_hit;

    assign run                 = (state_reg == ST_RUN);
    assign redirect_pc_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    // Request valid comes from registered state only. A redirect never
    // gates it combinationally. A request accepted in a redirect cycle is
    // simply counted as wrong-path in drop_cnt.
    assign imem_req_valid = run &&
                            (({1'b0, occ_reg} + {1'b0, out_cnt_reg}) < DEPTH_SUM);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Once halted, redirects are ignored. Only reset leaves HALT.
    assign redirect_take  = redirect_valid && (state_reg != ST_HALT);
    assign flush          = redirect_take || (state_reg == ST_HALT);
    assign rsp_drop       = (drop_cnt_reg != '0);
    assign fifo_wr        = imem_rsp_valid && !rsp_drop && !redirect_take && run;

    assign if_valid       = (occ_reg != '0);
    assign fifo_rd        = if_valid && if_ready;
    // Head contents are masked while empty, so the outputs read 0 after reset.
    assign if_inst        = if_valid ? fifo_inst_mem[rd_ptr_reg] : '0;
    assign if_pc          = if_valid ? fifo_pc_mem[rd_ptr_reg]   : '0;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned_reg;
    assign misalign_hit     = redirect_take && (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = misaligned_reg;
`else
    assign misalign_hit     = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        out_cnt_next  = out_cnt_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_next = drop_cnt_reg;
        occ_next      = occ_reg + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
        wr_ptr_next   = wr_ptr_reg + PTR_W'(fifo_wr);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(fifo_rd);

        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_HALT;
        endcase
        if (misalign_hit) begin
            state_next = ST_HALT;
        end

        if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
        end

        // Every response still in flight after this cycle belongs to the
        // wrong path. That includes a request accepted this same cycle and
        // excludes a response consumed this same cycle.
        if (redirect_take) begin
            fetch_pc_next = redirect_pc_aligned;
            drop_cnt_next = out_cnt_next;
        end else if (imem_rsp_valid && rsp_drop) begin
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        end

        if (flush) begin
            occ_next    = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_BOOT;
            fetch_pc_reg   <= RESET_PC;
            out_cnt_reg    <= '0;
            drop_cnt_reg   <= '0;
            occ_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            trk_wr_ptr_reg <= '0;
            trk_rd_ptr_reg <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misaligned_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            out_cnt_reg    <= out_cnt_next;
            drop_cnt_reg   <= drop_cnt_next;
            occ_reg        <= occ_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            // The tracker is never flushed. Each dropped response still
            // retires its address slot.
            trk_wr_ptr_reg <= trk_wr_ptr_reg + PTR_W'(req_fire);
            trk_rd_ptr_reg <= trk_rd_ptr_reg + PTR_W'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHK_EN
            if (misalign_hit) begin
                misaligned_reg <= 1'b1;
            end
`endif
        end
    end

    // Storage arrays need no reset. Occupancy and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            trk_mem[trk_wr_ptr_reg] <= fetch_pc_reg;
        end
        if (fifo_wr) begin
            fifo_inst_mem[wr_ptr_reg] <= imem_rsp_data;
            fifo_pc_mem[wr_ptr_reg]   <= trk_mem[trk_rd_ptr_reg];
        end
    end

endmodule
